// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: captures two operands and a carry-in on start, then
// resolves one bit pair per clock through a single full-add step, LSB first.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         C_out
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [N-1:0]   a_sh_q;
  logic [N-1:0]   b_sh_q;
  logic [N-1:0]   sum_sh_q;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   s_q;
  logic           c_out_q;

  logic [1:0]     step_d;
  logic [N-1:0]   sum_sh_d;

  // One-bit full-add cell; the 2-bit result keeps the carry untruncated.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

  // Current full-add step and the sum register after this bit shifts in.
  always_comb begin
    step_d   = full_add(a_sh_q[0], b_sh_q[0], carry_q);
    sum_sh_d = N'({step_d[0], sum_sh_q} >> 1);
  end

  // Sequencer: operand capture, per-bit shifting and result hand-off.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s_q      <= '0;
      c_out_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sh_q   <= A;
            b_sh_q   <= B;
            carry_q  <= C_in;
            cnt_q    <= '0;
            sum_sh_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_ADD;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_ADD: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          carry_q  <= step_d[1];
          cnt_q    <= cnt_q + CW'(1);
          // Last bit: publish the result on the same edge it completes.
          if (cnt_q == CW'(N - 1)) begin
            s_q     <= sum_sh_d;
            c_out_q <= step_d[1];
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_ADD;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign C_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and back-to-back checks of serial_adder at N=8; outputs are
// sampled on the falling edge, inputs driven just after it.
module tb_serial_adder;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         C_in;
  logic         busy;
  logic         done;
  logic [N-1:0] S;
  logic         C_out;

  int total;
  int bad;
  logic [N-1:0] prev_s;
  logic         prev_c;

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .C_out (C_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One addition from IDLE; poke > 0 raises start with A=F0 before edge k+poke.
  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                    input logic [N-1:0] es, input logic ec, input int poke);
    A = a; B = b; C_in = cin; start = 1'b1;
    cyc();
    start = 1'b0; A = 8'h00; B = 8'h00; C_in = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("done_after_accept", done, 1'b0);
    for (int i = 1; i <= N; i++) begin
      if (i == poke) begin
        start = 1'b1; A = 8'hF0; B = 8'h0F;
      end else begin
        start = 1'b0;
      end
      cyc();
      check("busy_in_add", busy, 1'b1);
      check("done_timing", done, (i == N));
      if (i < N) begin
        check("s_held", S, prev_s);
        check("cout_held", C_out, prev_c);
      end else begin
        check("sum", S, es);
        check("cout", C_out, ec);
      end
    end
    start = 1'b0;
    cyc();
    check("busy_after_done", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
    check("sum_stable", S, es);
    prev_s = es;
    prev_c = ec;
  endtask

  initial begin
    logic [N:0]   exp_b2b;
    logic         got;
    int           cycles;
    int           last_done;

    total = 0; bad = 0;
    prev_s = 8'h00; prev_c = 1'b0;
    reset = 1'b1; start = 1'b1; A = 8'h12; B = 8'h34; C_in = 1'b1;
    @(negedge clk);

    // Reset held 2 cycles with start high
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_s", S, 8'h00);
      check("rst_cout", C_out, 1'b0);
    end
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("idle_busy", busy, 1'b0);
    end

    op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 0);
    op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0);
    op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
    op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 3);

    // Reset at edge k+4 abandons the addition
    A = 8'h77; B = 8'h11; C_in = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) cyc();
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_s", S, 8'h00);
    check("midrst_cout", C_out, 1'b0);
    for (int i = 0; i < N + 2; i++) begin
      cyc();
      check("midrst_no_done", done, 1'b0);
    end
    prev_s = 8'h00; prev_c = 1'b0;
    op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);

    // Back-to-back with start held high
    cycles = 0; last_done = 0;
    A = N'($urandom_range(0, 255)); B = N'($urandom_range(0, 255)); C_in = 1'($urandom_range(0, 1));
    exp_b2b = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, C_in};
    start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        cyc();
        cycles++;
        if (done) got = 1'b1;
      end
      if (!got) begin
        check("b2b_timeout", 1'b0, 1'b1);
        break;
      end
      check("b2b_sum", S, exp_b2b[N-1:0]);
      check("b2b_cout", C_out, exp_b2b[N]);
      if (n > 0) check("b2b_gap", cycles - last_done, N + 2);
      last_done = cycles;
      A = N'($urandom_range(0, 255)); B = N'($urandom_range(0, 255)); C_in = 1'($urandom_range(0, 1));
      exp_b2b = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, C_in};
    end
    start = 1'b0;
    repeat (N + 4) cyc();
    check("drain_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
